pipeline_stall_ctrl: RTL and testbench
======================================

// Module: pipeline_stall_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage RV32 pipeline. Merges the load-use request from hazard
//  detection, data-memory wait (req/ready handshake) and EX-stage branch redirect into one set of per-stage
//  write-enable/flush controls. Owns a MEM_WAIT FSM with timeout so a hung data memory cannot freeze the core.
// PARAMETERS
//  MEM_TIMEOUT  64  max consecutive MEM_WAIT cycles before forced abort (>=2)
//  CNT_WIDTH    7   width of wait counter; must satisfy 2**CNT_WIDTH > MEM_TIMEOUT
// PORTS
//  clk             in   1   clock, rising edge
//  rst_n           in   1   asynchronous active-low reset
//  load_use_hazard in   1   load in ID/EX whose rd matches IF/ID rs1/rs2 (1 = stall request)
//  dmem_req        in   1   EX/MEM instruction is a load/store accessing data memory
//  dmem_ready      in   1   data memory completes access this cycle
//  branch_taken    in   1   EX resolves taken branch/jump (redirect PC this cycle)
//  pc_write        out  1   PC register write enable
//  IF_ID_write     out  1   IF/ID register write enable
//  IF_ID_flush     out  1   IF/ID loads NOP
//  ID_EX_flush     out  1   ID/EX loads bubble (control select to zero)
//  EX_MEM_write    out  1   EX/MEM register write enable
//  MEM_WB_flush    out  1   MEM/WB loads bubble
//  mem_timeout     out  1   one-cycle pulse: MEM_WAIT aborted by timeout
// BEHAVIOUR
//  - States: RUN (reset), MEM_WAIT. Outputs combinational from state + inputs; counter registered.
//  - Reset (rst_n=0): state=RUN, wait_cnt=0; pc_write=IF_ID_write=EX_MEM_write=0, IF_ID_flush=ID_EX_flush=
//    MEM_WB_flush=1, mem_timeout=0. Async assert; release takes effect at next rising edge.
//  - Priority per cycle: memory wait > branch_taken > load_use_hazard > normal advance.
//  - RUN, dmem_req & !dmem_ready: freeze PC, IF/ID, ID/EX (flush=0), EX/MEM (write=0); MEM_WB_flush=1;
//    branch_taken/load_use ignored this cycle; next state MEM_WAIT, wait_cnt<=1.
//  - RUN, dmem_req & dmem_ready (single-cycle access) or !dmem_req: no memory stall.
//  - RUN, branch_taken (no mem stall): pc_write=1, IF_ID_flush=1, ID_EX_flush=1, others advance. Same-cycle
//    load_use_hazard is discarded (the stalled instruction is being flushed).
//  - RUN, load_use_hazard only: pc_write=0, IF_ID_write=0, ID_EX_flush=1; EX_MEM/MEM_WB advance. One bubble
//    per assertion; hazard clears naturally next cycle.
//  - RUN, none: all write enables 1, all flushes 0.
//  - MEM_WAIT: same freeze outputs as entry. dmem_ready=1 -> release this cycle: EX_MEM_write=1,
//    MEM_WB_flush=0, PC/IF_ID/ID_EX advance unless load_use_hazard (then load-use stall applies same cycle);
//    next RUN, wait_cnt<=0. Pending branch_taken held in EX is honoured in that release cycle.
//  - Timeout: in MEM_WAIT with wait_cnt==MEM_TIMEOUT and !dmem_ready -> mem_timeout=1 for that cycle, MEM_WB
//    flush=1, EX_MEM_write=1 (drop access), next RUN, wait_cnt<=0. dmem_ready on the timeout cycle wins (no pulse).
//  - wait_cnt saturates at MEM_TIMEOUT; never wraps. Reset mid-MEM_WAIT returns to RUN, no timeout pulse.
// CONFIGURATION
//  STALL_PERF_CNT_EN defined: adds outputs stall_cycles[31:0] (increments every cycle pc_write=0 after reset)
//    and flush_events[31:0] (increments each cycle IF_ID_flush=1 in RUN due to branch_taken); both reset to 0,
//    wrap at 2**32. Undefined: ports and counters absent; control behaviour identical.
// TESTING
//  1 Reset held 3 cycles -> pc_write=0, all flushes=1; release, idle inputs -> all writes 1, flushes 0.
//  2 load_use_hazard=1 one cycle -> pc_write=0, IF_ID_write=0, ID_EX_flush=1 for exactly 1 cycle.
//  3 dmem_req=1, dmem_ready low 4 cycles then high -> EX_MEM_write=0 and MEM_WB_flush=1 for 4 cycles,
//    release on 5th; no mem_timeout.
//  4 MEM_TIMEOUT=4, dmem_ready never -> mem_timeout pulses once on 5th stall cycle, state back to RUN.
//  5 branch_taken with load_use_hazard same cycle -> IF_ID_flush=ID_EX_flush=1, pc_write=1; no extra stall.
//  6 rst_n low mid-MEM_WAIT -> immediate reset outputs; after release RUN, wait_cnt=0, no pulse.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: load-use, data-memory wait with timeout, branch flush.
// Optional STALL_PERF_CNT_EN adds stall-cycle and branch-flush event counters.
module pipeline_stall_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_WIDTH   = 7
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load_use_hazard,
    input  logic        i_dmem_req,
    input  logic        i_dmem_ready,
    input  logic        i_branch_taken,
    output logic        o_pc_write,
    output logic        o_IF_ID_write,
    output logic        o_IF_ID_flush,
    output logic        o_ID_EX_flush,
    output logic        o_EX_MEM_write,
    output logic        o_MEM_WB_flush,
    output logic        o_mem_timeout
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0] o_stall_cycles,
    output logic [31:0] o_flush_events
`endif
);

    typedef enum logic {ST_RUN, ST_MEM_WAIT} state_t;

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(MEM_TIMEOUT);

    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_wait_cnt;

    logic w_mem_stall_run;
    logic w_timeout;
    logic w_freeze;

    assign w_mem_stall_run = (r_state == ST_RUN) && i_dmem_req && !i_dmem_ready;
    assign w_timeout       = (r_state == ST_MEM_WAIT) && !i_dmem_ready && (r_wait_cnt == TIMEOUT_CNT);
    assign w_freeze        = w_mem_stall_run || ((r_state == ST_MEM_WAIT) && !i_dmem_ready && !w_timeout);

    // Timeout and ready-release share the release path; a timeout only bubbles MEM/WB and pulses the flag.
    always_comb begin
        o_pc_write     = 1'b1;
        o_IF_ID_write  = 1'b1;
        o_IF_ID_flush  = 1'b0;
        o_ID_EX_flush  = 1'b0;
        o_EX_MEM_write = 1'b1;
        o_MEM_WB_flush = 1'b0;
        o_mem_timeout  = 1'b0;
        if (!i_rst_n) begin
            o_pc_write     = 1'b0;
            o_IF_ID_write  = 1'b0;
            o_IF_ID_flush  = 1'b1;
            o_ID_EX_flush  = 1'b1;
            o_EX_MEM_write = 1'b0;
            o_MEM_WB_flush = 1'b1;
        end else if (w_freeze) begin
            o_pc_write     = 1'b0;
            o_IF_ID_write  = 1'b0;
            o_EX_MEM_write = 1'b0;
            o_MEM_WB_flush = 1'b1;
        end else begin
            if (w_timeout) begin
                o_MEM_WB_flush = 1'b1;
                o_mem_timeout  = 1'b1;
            end
            if (i_branch_taken) begin
                o_IF_ID_flush = 1'b1;
                o_ID_EX_flush = 1'b1;
            end else if (i_load_use_hazard) begin
                o_pc_write    = 1'b0;
                o_IF_ID_write = 1'b0;
                o_ID_EX_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_mem_stall_run) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= CNT_WIDTH'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (i_dmem_ready || w_timeout) begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt != TIMEOUT_CNT) begin
                        r_wait_cnt <= r_wait_cnt + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic w_branch_flush_run;

    assign w_branch_flush_run = (r_state == ST_RUN) && i_branch_taken && !w_mem_stall_run;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stall_cycles <= '0;
            o_flush_events <= '0;
        end else begin
            if (!o_pc_write) begin
                o_stall_cycles <= o_stall_cycles + 32'd1;
            end
            if (w_branch_flush_run) begin
                o_flush_events <= o_flush_events + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: directed per-cycle vectors push expected control words,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipeline_stall_ctrl;

    // Expected word order: {pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, EX_MEM_write, MEM_WB_flush, mem_timeout}
    localparam logic [6:0] EXP_RESET = 7'b0011010;
    localparam logic [6:0] EXP_ADV   = 7'b1100100;
    localparam logic [6:0] EXP_LU    = 7'b0001100;
    localparam logic [6:0] EXP_MEMF  = 7'b0000010;
    localparam logic [6:0] EXP_BR    = 7'b1111100;
    localparam logic [6:0] EXP_TO    = 7'b1100111;

    typedef struct {
        logic [6:0] expWord;
        string      tag;
    } expEntry_t;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic loadUse = 1'b0;
    logic dmemReq = 1'b0;
    logic dmemReady = 1'b0;
    logic branchTaken = 1'b0;

    logic pcWrite, ifIdWrite, ifIdFlush, idExFlush, exMemWrite, memWbFlush, memTimeout;
`ifdef STALL_PERF_CNT_EN
    logic [31:0] stallCycles, flushEvents;
`endif

    expEntry_t expQ[$];
    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(
        .MEM_TIMEOUT(4),
        .CNT_WIDTH  (3)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rstN),
        .i_load_use_hazard(loadUse),
        .i_dmem_req       (dmemReq),
        .i_dmem_ready     (dmemReady),
        .i_branch_taken   (branchTaken),
        .o_pc_write       (pcWrite),
        .o_IF_ID_write    (ifIdWrite),
        .o_IF_ID_flush    (ifIdFlush),
        .o_ID_EX_flush    (idExFlush),
        .o_EX_MEM_write   (exMemWrite),
        .o_MEM_WB_flush   (memWbFlush),
        .o_mem_timeout    (memTimeout)
`ifdef STALL_PERF_CNT_EN
        ,
        .o_stall_cycles   (stallCycles),
        .o_flush_events   (flushEvents)
`endif
    );

    task automatic applyStimulus(input logic rst, input logic lu, input logic req, input logic rdy,
                                 input logic br, input logic [6:0] expWord, input string tag);
        expEntry_t e;
        @(posedge clk);
        #1;
        rstN        = rst;
        loadUse     = lu;
        dmemReq     = req;
        dmemReady   = rdy;
        branchTaken = br;
        e.expWord   = expWord;
        e.tag       = tag;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input expEntry_t e);
        logic [6:0] actual;
        actual = {pcWrite, ifIdWrite, ifIdFlush, idExFlush, exMemWrite, memWbFlush, memTimeout};
        checkCount++;
        if (actual !== e.expWord) begin
            errorCount++;
            $display("[TB] FAIL %s: got %b expected %b", e.tag, actual, e.expWord);
        end
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            checkOutput(expQ.pop_front());
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset held three cycles, then idle advance
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, EXP_RESET, "reset_hold");
        applyStimulus(0, 1, 1, 0, 1, EXP_RESET, "reset_ignores_inputs");
        applyStimulus(1, 0, 0, 0, 0, EXP_ADV, "idle_after_reset");
        applyStimulus(1, 0, 0, 0, 0, EXP_ADV, "idle_2");

        // Single load-use bubble
        applyStimulus(1, 1, 0, 0, 0, EXP_LU, "load_use");
        applyStimulus(1, 0, 0, 0, 0, EXP_ADV, "load_use_cleared");

        // Four-cycle memory wait; ready arrives exactly on the timeout cycle and wins
        applyStimulus(1, 0, 1, 0, 0, EXP_MEMF, "mem_wait_1");
        applyStimulus(1, 1, 1, 0, 1, EXP_MEMF, "mem_wait_2_ignores_br_lu");
        applyStimulus(1, 0, 1, 0, 0, EXP_MEMF, "mem_wait_3");
        applyStimulus(1, 0, 1, 0, 0, EXP_MEMF, "mem_wait_4");
        applyStimulus(1, 0, 1, 1, 0, EXP_ADV, "mem_release_at_limit");
        applyStimulus(1, 0, 0, 0, 0, EXP_ADV, "after_release");

        // Timeout: ready never arrives
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, 0, 0, EXP_MEMF, "timeout_stall");
        applyStimulus(1, 0, 1, 0, 0, EXP_TO, "timeout_pulse");
        applyStimulus(1, 0, 0, 0, 0, EXP_ADV, "after_timeout_run");
        applyStimulus(1, 0, 1, 1, 0, EXP_ADV, "single_cycle_access");

        // Branch with same-cycle load-use
        applyStimulus(1, 1, 0, 0, 1, EXP_BR, "branch_over_load_use");
        applyStimulus(1, 0, 0, 0, 0, EXP_ADV, "after_branch");

        // Memory stall outranks branch and load-use in RUN
        applyStimulus(1, 1, 1, 0, 1, EXP_MEMF, "mem_over_branch");
        applyStimulus(1, 0, 1, 1, 0, EXP_ADV, "release_plain");

        // Pending branch honoured on release; load-use applied on release
        applyStimulus(1, 0, 1, 0, 1, EXP_MEMF, "wait_with_branch");
        applyStimulus(1, 0, 1, 1, 1, EXP_BR, "release_with_branch");
        applyStimulus(1, 0, 1, 0, 0, EXP_MEMF, "wait_lu_1");
        applyStimulus(1, 1, 1, 0, 0, EXP_MEMF, "wait_lu_2");
        applyStimulus(1, 1, 1, 1, 0, EXP_LU, "release_with_load_use");
        applyStimulus(1, 0, 0, 0, 0, EXP_ADV, "idle_3");

        // Reset mid-wait, then a full timeout sequence proves the counter restarted from zero
        applyStimulus(1, 0, 1, 0, 0, EXP_MEMF, "pre_reset_wait_1");
        applyStimulus(1, 0, 1, 0, 0, EXP_MEMF, "pre_reset_wait_2");
        applyStimulus(0, 0, 1, 0, 0, EXP_RESET, "reset_mid_wait");
        applyStimulus(0, 0, 1, 0, 0, EXP_RESET, "reset_mid_wait_hold");
        applyStimulus(1, 0, 0, 0, 0, EXP_ADV, "run_after_reset");
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, 0, 0, EXP_MEMF, "post_reset_stall");
        applyStimulus(1, 0, 1, 0, 0, EXP_TO, "post_reset_timeout");
        applyStimulus(1, 0, 0, 0, 0, EXP_ADV, "final_idle");

        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (expQ.size() != 0) begin
            errorCount++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
